// File: rtl/gpu_ia_pkg.sv
// Shared constants and types for the GPU input-assembly front end.
// The packet length and index width here match the top-level scene register file.
package gpu_ia_pkg;

    localparam int PACKET_BYTES         = 60;
    localparam int IDX_W                = 7;
    localparam int CLKS_PER_BIT_DEFAULT = 217;

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } rxState_t;

endpackage

// File: rtl/ia_uart_loader_if.sv
// Bus between the UART loader and the scene register file.
// The master side is the loader: it samples the serial line and drives the write strobes.
interface ia_uart_loader_if;
    import gpu_ia_pkg::*;

    logic             rx;
    logic [7:0]       read_data;
    logic [IDX_W-1:0] idx;
    logic             update_reg;
    logic             pc_ready;
    logic             frame_err;
    logic             busy;

    modport master (
        input  rx,
        output read_data, idx, update_reg, pc_ready, frame_err, busy
    );

    modport slave (
        output rx,
        input  read_data, idx, update_reg, pc_ready, frame_err, busy
    );

endinterface

// File: rtl/uart_rx_byte.sv
// 8N1 byte receiver: line synchronizer, bit-timing FSM and LSB-first shift register.
// The valid or framing-error strobe is combinational, in the cycle the stop bit is sampled.
module uart_rx_byte #(
    parameter int CLKS_PER_BIT = gpu_ia_pkg::CLKS_PER_BIT_DEFAULT
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       i_rx,
    output logic       o_byteValid,
    output logic [7:0] o_byte,
    output logic       o_frameErr,
    output logic       o_idle
);
    import gpu_ia_pkg::*;

    localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] HALF_LOAD = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] FULL_LOAD = CNT_W'(CLKS_PER_BIT - 1);

    logic             r_sync1, r_sync2, r_rxPrev;
    rxState_t         r_state, w_nextState;
    logic [CNT_W-1:0] r_cnt, w_nextCnt;
    logic [2:0]       r_bitIdx, w_nextBitIdx;
    logic [7:0]       r_shift, w_nextShift;
    logic             w_fall, w_expire, w_byteValid, w_frameErr;

    assign w_fall   = r_rxPrev & ~r_sync2;
    assign w_expire = (r_cnt == '0);

    // Presetting the chain to the idle level keeps reset release from looking like a start edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1  <= 1'b1;
            r_sync2  <= 1'b1;
            r_rxPrev <= 1'b1;
        end else begin
            r_sync1  <= i_rx;
            r_sync2  <= r_sync1;
            r_rxPrev <= r_sync2;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= IDLE;
            r_cnt    <= HALF_LOAD;
            r_bitIdx <= 3'd0;
            r_shift  <= 8'd0;
        end else begin
            r_state  <= w_nextState;
            r_cnt    <= w_nextCnt;
            r_bitIdx <= w_nextBitIdx;
            r_shift  <= w_nextShift;
        end
    end

    // Counter reaching zero marks a sample point; each sample reloads a full bit period.
    always_comb begin
        w_nextState  = r_state;
        w_nextCnt    = w_expire ? FULL_LOAD : r_cnt - CNT_W'(1);
        w_nextBitIdx = r_bitIdx;
        w_nextShift  = r_shift;
        w_byteValid  = 1'b0;
        w_frameErr   = 1'b0;
        case (r_state)
            IDLE: begin
                w_nextCnt = HALF_LOAD;
                if (w_fall) w_nextState = START;
            end
            START: begin
                if (w_expire) begin
                    w_nextBitIdx = 3'd0;
                    w_nextState  = r_sync2 ? IDLE : DATA;
                end
            end
            DATA: begin
                if (w_expire) begin
                    w_nextShift  = {r_sync2, r_shift[7:1]};
                    w_nextBitIdx = r_bitIdx + 3'd1;
                    if (r_bitIdx == 3'd7) w_nextState = STOP;
                end
            end
            STOP: begin
                if (w_expire) begin
                    w_nextState = IDLE;
                    w_byteValid = r_sync2;
                    w_frameErr  = ~r_sync2;
                end
            end
            default: w_nextState = IDLE;
        endcase
    end

    assign o_byteValid = w_byteValid;
    assign o_frameErr  = w_frameErr;
    assign o_byte      = r_shift;
    assign o_idle      = (r_state == IDLE);

endmodule

// File: rtl/ia_uart_loader.sv
// Scene-packet loader: turns received UART bytes into indexed register-file writes
// and flags packet completion; a long mid-packet silence resynchronises the index.
module ia_uart_loader #(
    parameter int CLKS_PER_BIT = gpu_ia_pkg::CLKS_PER_BIT_DEFAULT,
    parameter int PACKET_BYTES = gpu_ia_pkg::PACKET_BYTES,
    parameter int TIMEOUT_CLKS = 4340
) (
    input  logic              clk,
    input  logic              rst_n,
    ia_uart_loader_if.master  bus
);
    import gpu_ia_pkg::*;

    localparam int TO_W = (TIMEOUT_CLKS > 1) ? $clog2(TIMEOUT_CLKS) : 1;
    localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TIMEOUT_CLKS - 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(PACKET_BYTES - 1);

    logic             w_byteValid, w_frameErr, w_idle, w_timeout;
    logic [7:0]       w_byte;
    logic [7:0]       r_readData;
    logic [IDX_W-1:0] r_idx, r_pktIdx;
    logic             r_updateReg, r_frameErr, r_pcReady;
    logic [TO_W-1:0]  r_toCnt;

    uart_rx_byte #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_rx (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_rx        (bus.rx),
        .o_byteValid (w_byteValid),
        .o_byte      (w_byte),
        .o_frameErr  (w_frameErr),
        .o_idle      (w_idle)
    );

    assign w_timeout = w_idle && (r_pktIdx != '0) && (r_toCnt == TO_LAST);

    // pc_ready trails the strobe for the last byte by one cycle, never overlapping it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_readData  <= 8'd0;
            r_idx       <= '0;
            r_pktIdx    <= '0;
            r_updateReg <= 1'b0;
            r_frameErr  <= 1'b0;
            r_pcReady   <= 1'b0;
        end else begin
            r_updateReg <= w_byteValid;
            r_frameErr  <= w_frameErr;
            r_pcReady   <= r_updateReg && (r_idx == LAST_IDX);
            if (w_byteValid) begin
                r_readData <= w_byte;
                r_idx      <= r_pktIdx;
                r_pktIdx   <= (r_pktIdx == LAST_IDX) ? '0 : r_pktIdx + IDX_W'(1);
            end else if (w_frameErr || w_timeout) begin
                r_pktIdx   <= '0;
            end
        end
    end

    // Counts consecutive idle cycles only while a packet is partially received.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_toCnt <= '0;
        end else if (w_idle && (r_pktIdx != '0) && !w_timeout) begin
            r_toCnt <= r_toCnt + TO_W'(1);
        end else begin
            r_toCnt <= '0;
        end
    end

    assign bus.read_data  = r_readData;
    assign bus.idx        = r_idx;
    assign bus.update_reg = r_updateReg;
    assign bus.frame_err  = r_frameErr;
    assign bus.pc_ready   = r_pcReady;
    assign bus.busy       = ~w_idle | (r_pktIdx != '0);

endmodule

// File: doc/ia_uart_loader.md
# ia_uart_loader

Serial front end of the tiniest GPU. It receives the 60-byte scene packet (vertices, normal, light, VP matrix, render mode) over an 8N1 UART on `ui_in[3]`. Each byte goes to the top-level register file as a one-cycle write strobe carrying the data and its byte index. A single completion pulse fires after the last byte, and downstream it is registered into `pc_data_ready` to start the vertex stage.

## Interface
Parameters:
- `CLKS_PER_BIT`, 217: clock cycles per UART bit (25 MHz / 115200).
- `PACKET_BYTES`, 60: bytes per packet; `idx` runs 0..`PACKET_BYTES`-1.
- `TIMEOUT_CLKS`, 4340: idle cycles (≈20 bit times) mid-packet before the index resyncs to 0.

Ports:
- `clk`, in, 1: pixel clock. The block uses one clock.
- `rst_n`, in, 1: reset, asynchronous and active-low.
- `rx`, in, 1: UART line, idle high, asynchronous to `clk`.
- `read_data`, out, 8: received byte; valid while `update_reg`=1.
- `idx`, out, 7: packet position of `read_data`; valid while `update_reg`=1.
- `update_reg`, out, 1: one-cycle write strobe.
- `pc_ready`, out, 1: one-cycle packet-complete pulse.
- `frame_err`, out, 1: one-cycle pulse on a bad stop bit.
- `busy`, out, 1: high while a byte is in flight or the packet is partially received.

## Operation
- `rx` passes through a 2-flop synchronizer, preset to 1. All logic uses the synchronized value `rx_s`.
- Bit FSM, states IDLE → START → DATA → STOP → IDLE:
  - **IDLE:** a `rx_s` falling edge loads the bit counter with `CLKS_PER_BIT/2` (integer division) and moves to START.
  - **START:** when the counter expires, sample `rx_s`. If 1, treat it as a false start and return to IDLE with no output. If 0, move to DATA.
  - **DATA:** sample every `CLKS_PER_BIT` cycles, LSB first, into a shift register. After bit 7, move to STOP.
  - **STOP:** sample after `CLKS_PER_BIT` cycles.
    - If 1: the byte is valid. Present it with the current packet index and pulse `update_reg`.
    - If 0: pulse `frame_err`, drop the byte, and set the packet index to 0.
    - In both cases, return to IDLE in the same cycle, so a start edge that immediately follows is caught.
- Packet indexer (`pkt_idx`, 7 bits):
  - Increments after each valid byte.
  - On the byte with `pkt_idx` = `PACKET_BYTES`-1: wraps to 0 and sets a one-shot that drives `pc_ready` on the next cycle.
- Timeout: when `pkt_idx` ≠ 0 and the FSM has sat in IDLE for `TIMEOUT_CLKS` consecutive cycles, `pkt_idx` ← 0. No output pulse is generated.
- Simultaneous events: a start edge detected in the same cycle the timeout expires is still received, and that byte takes `idx` 0.

## Timing
- Reset values: `read_data`=0, `idx`=0, `update_reg`=0, `pc_ready`=0, `frame_err`=0, `busy`=0. Internally: FSM=IDLE, `pkt_idx`=0, synchronizer=1.
- Reset mid-byte or mid-packet aborts everything. The first byte after reset gets `idx` 0.
- Sample points, with E = cycle the falling edge is seen on `rx_s`:
  - Start bit at E + `CLKS_PER_BIT/2`.
  - Data bit k at E + `CLKS_PER_BIT/2` + (k+1)·`CLKS_PER_BIT`.
  - Stop bit at E + `CLKS_PER_BIT/2` + 9·`CLKS_PER_BIT`.
- `update_reg` / `frame_err` go high the cycle after the stop sample. `read_data` and `idx` are registered and stable during that cycle.
- `pc_ready` goes high exactly 1 cycle after the `update_reg` for `idx` = `PACKET_BYTES`-1, which is never the same cycle.
- `busy` = (FSM ≠ IDLE) or (`pkt_idx` ≠ 0).

## Structure
- Shared package `gpu_ia_pkg` holds:
  - `PACKET_BYTES`
  - `IDX_W`=7
  - the bit-FSM state enum (IDLE/START/DATA/STOP)
  - the default `CLKS_PER_BIT`
- Sub-module `uart_rx_byte` contains the synchronizer, bit FSM and shift register. It outputs `byte_valid`, `byte`, `frame_err` and `idle`.
- `ia_uart_loader` wraps `uart_rx_byte` and adds the packet indexer, the timeout counter and the `pc_ready` one-shot.

## Test plan
- **Full packet:** `CLKS_PER_BIT`=8, bytes 0x00..0x3B back-to-back → 60 `update_reg` pulses with `read_data`=`idx`=n. One `pc_ready` arrives 1 cycle after the pulse for `idx` 59, and `busy` falls afterwards.
- **Glitch:** `rx` held low for 3 cycles only (< `CLKS_PER_BIT/2`) → no `update_reg`, no `frame_err`, FSM back in IDLE.
- **Framing error:** 5 good bytes, then byte 0xA5 sent with a stop bit of 0 → `frame_err` pulse and no `update_reg` for it. The next good byte 0x11 appears with `idx` 0.
- **Timeout:** 10 bytes, then idle for `TIMEOUT_CLKS`+1 cycles, then byte 0x77 → `idx` 0 and no `pc_ready`.
- **Reset mid-byte:** assert `rst_n`=0 during data bit 3 of byte 20 → all outputs reach their reset values without waiting for a clock edge. The next full byte after release gets `idx` 0.
- **Two packets:** two packets back-to-back, with the next start bit beginning right after the stop-bit sample → second packet indices restart at 0 and `pc_ready` pulses twice.
